// File: rtl/multicycle_ctrl_if.sv
// Handshake/bus bundle between the multicycle sequencer and its datapath.
// i_* flow into the controller, o_* flow out of it (master = controller).
interface multicycle_ctrl_if;
    logic [31:0] i_inst;
    logic        i_imem_ack;
    logic        i_dmem_ack;
    logic        i_branch_taken;
    logic        o_imem_req;
    logic        o_ir_write;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic        o_reg_write;
    logic [1:0]  o_wb_sel;
    logic        o_pc_write;
    logic [1:0]  o_pc_src;
    logic [2:0]  o_state;
    logic [1:0]  o_fault_cause;
    logic [31:0] o_retired;

    modport master (
        input  i_inst, i_imem_ack, i_dmem_ack, i_branch_taken,
        output o_imem_req, o_ir_write, o_dmem_req, o_dmem_we,
        output o_reg_write, o_wb_sel, o_pc_write, o_pc_src,
        output o_state, o_fault_cause, o_retired
    );

    modport slave (
        output i_inst, i_imem_ack, i_dmem_ack, i_branch_taken,
        input  o_imem_req, o_ir_write, o_dmem_req, o_dmem_we,
        input  o_reg_write, o_wb_sel, o_pc_write, o_pc_src,
        input  o_state, o_fault_cause, o_retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Ports: clk, rst (sync, active-high), bus (multicycle_ctrl_if.master).
module multicycle_ctrl #(
    parameter logic [2:0]  RESET_STATE  = 3'd0,
    parameter int unsigned MEM_WAIT_MAX = 8
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_L, C_S, C_B, C_J, C_JALR, C_LUI, C_AUIPC, C_SYS
    } cls_t;

    localparam logic [31:0] LIM =
        (MEM_WAIT_MAX == 0) ? 32'd0 : 32'(MEM_WAIT_MAX - 1);

    state_t      r_state, w_state_n;
    cls_t        r_cls, w_cls_n, w_dec_cls;
    logic        w_dec_ok;
    logic [1:0]  r_fault, w_fault_n;
    logic [31:0] r_ret;
    logic [31:0] r_wait, w_wait_n;
    logic        w_inc, w_to;
    logic        w_imem_req, w_ir_write, w_dmem_req, w_dmem_we;
    logic        w_reg_write, w_pc_write;
    logic [1:0]  w_wb_sel, w_pc_src;
    logic        w_unused;

    assign w_unused = ^{bus.i_inst[31:12]};

    // Last allowed no-ack cycle reached; an ack this cycle still wins.
    assign w_to = (MEM_WAIT_MAX != 0) && (r_wait == LIM);

    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_cls = C_R;
        case (bus.i_inst[6:0])
            7'b0110011: w_dec_cls = C_R;
            7'b0010011: w_dec_cls = C_I;
            7'b0000011: w_dec_cls = C_L;
            7'b0100011: w_dec_cls = C_S;
            7'b1100011: w_dec_cls = C_B;
            7'b1101111: w_dec_cls = C_J;
            7'b1100111: w_dec_cls = C_JALR;
            7'b0110111: w_dec_cls = C_LUI;
            7'b0010111: w_dec_cls = C_AUIPC;
            7'b1110011: w_dec_cls = C_SYS;
            default:    w_dec_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= state_t'(RESET_STATE);
            r_cls   <= C_R;
            r_fault <= 2'd0;
            r_ret   <= 32'd0;
            r_wait  <= 32'd0;
        end else begin
            r_state <= w_state_n;
            r_cls   <= w_cls_n;
            r_fault <= w_fault_n;
            r_ret   <= r_ret + {31'd0, w_inc};
            r_wait  <= w_wait_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_cls_n     = r_cls;
        w_fault_n   = r_fault;
        // Cleared outside FETCH/MEM, so every entry starts from zero.
        w_wait_n    = 32'd0;
        w_inc       = 1'b0;
        w_imem_req  = 1'b0;
        w_ir_write  = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_reg_write = 1'b0;
        w_wb_sel    = 2'd0;
        w_pc_write  = 1'b0;
        w_pc_src    = 2'd0;
        unique case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.i_imem_ack) begin
                    w_ir_write = 1'b1;
                    w_state_n  = S_DECODE;
                end else if (w_to) begin
                    w_state_n = S_FAULT;
                    w_fault_n = 2'd2;
                end else if (r_wait != '1) begin
                    w_wait_n = r_wait + 32'd1;
                end else begin
                    w_wait_n = r_wait;
                end
            end
            S_DECODE: begin
                w_cls_n = w_dec_cls;
                if (!w_dec_ok) begin
                    w_state_n = S_FAULT;
                    w_fault_n = 2'd1;
                end else if (w_dec_cls == C_SYS) begin
                    w_state_n = S_HALT;
                    w_inc     = 1'b1;
                end else begin
                    w_state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cls == C_L || r_cls == C_S) begin
                    w_state_n = S_MEM;
                end else if (r_cls == C_B) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = {1'b0, bus.i_branch_taken};
                    w_inc      = 1'b1;
                    w_state_n  = S_FETCH;
                end else begin
                    w_state_n = S_WB;
                end
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (r_cls == C_S);
                if (bus.i_dmem_ack) begin
                    if (r_cls == C_S) begin
                        w_pc_write = 1'b1;
                        w_inc      = 1'b1;
                        w_state_n  = S_FETCH;
                    end else begin
                        w_state_n = S_WB;
                    end
                end else if (w_to) begin
                    w_state_n = S_FAULT;
                    w_fault_n = 2'd3;
                end else if (r_wait != '1) begin
                    w_wait_n = r_wait + 32'd1;
                end else begin
                    w_wait_n = r_wait;
                end
            end
            S_WB: begin
                w_reg_write = (bus.i_inst[11:7] != 5'd0);
                w_pc_write  = 1'b1;
                w_inc       = 1'b1;
                w_state_n   = S_FETCH;
                unique case (1'b1)
                    r_cls == C_L:   w_wb_sel = 2'd1;
                    r_cls == C_J:   w_wb_sel = 2'd2;
                    r_cls == C_JALR: w_wb_sel = 2'd2;
                    r_cls == C_LUI: w_wb_sel = 2'd3;
                    default:        w_wb_sel = 2'd0;
                endcase
                unique case (1'b1)
                    r_cls == C_J:    w_pc_src = 2'd1;
                    r_cls == C_JALR: w_pc_src = 2'd2;
                    default:         w_pc_src = 2'd0;
                endcase
            end
            default: begin
                w_state_n = r_state;
            end
        endcase
    end

    // Reset cycle must never leak a write or PC strobe.
    assign bus.o_imem_req    = w_imem_req & ~rst;
    assign bus.o_ir_write    = w_ir_write & ~rst;
    assign bus.o_dmem_req    = w_dmem_req & ~rst;
    assign bus.o_dmem_we     = w_dmem_we & ~rst;
    assign bus.o_reg_write   = w_reg_write & ~rst;
    assign bus.o_wb_sel      = w_wb_sel & {2{~rst}};
    assign bus.o_pc_write    = w_pc_write & ~rst;
    assign bus.o_pc_src      = w_pc_src & {2{~rst}};
    assign bus.o_state       = r_state;
    assign bus.o_fault_cause = r_fault;
    assign bus.o_retired     = r_ret;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, directed
// corner sequences and randomized instructions vs an instruction-level model.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .RESET_STATE (3'd0),
        .MEM_WAIT_MAX(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          rst;
        bit          ia;
        bit          da;
        bit          bt;
        logic [31:0] inst;
        bit          ireq;
        bit          irw;
        bit          dreq;
        bit          dwe;
        bit          rw;
        logic [1:0]  wsel;
        bit          pcw;
        logic [1:0]  psrc;
        logic [2:0]  st;
        logic [1:0]  fc;
        logic [31:0] ret;
    } cyc_t;

    int checks = 0;
    int passed = 0;
    int cyc_no = 0;

    cyc_t q[$];
    bit          m_dead = 0;
    logic [2:0]  m_st = 0;
    logic [1:0]  m_fc = 0;
    logic [31:0] m_ret = 0;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011,
        OP_L = 7'b0000011, OP_S = 7'b0100011, OP_B = 7'b1100011,
        OP_J = 7'b1101111, OP_JR = 7'b1100111, OP_LUI = 7'b0110111,
        OP_AUI = 7'b0010111, OP_SYS = 7'b1110011;

    function automatic cyc_t mk(bit r, bit ia, bit da, bit bt,
        logic [31:0] inst, bit ireq, bit irw, bit dreq, bit dwe, bit rw,
        logic [1:0] wsel, bit pcw, logic [1:0] psrc, logic [2:0] st,
        logic [1:0] fc, logic [31:0] ret);
        cyc_t c;
        c.rst = r; c.ia = ia; c.da = da; c.bt = bt; c.inst = inst;
        c.ireq = ireq; c.irw = irw; c.dreq = dreq; c.dwe = dwe;
        c.rw = rw; c.wsel = wsel; c.pcw = pcw; c.psrc = psrc;
        c.st = st; c.fc = fc; c.ret = ret;
        return c;
    endfunction

    function automatic bit legal(logic [6:0] op);
        return op inside {OP_R, OP_I, OP_L, OP_S, OP_B, OP_J, OP_JR,
                          OP_LUI, OP_AUI, OP_SYS};
    endfunction

    // A cycle with no strobes, the model's current state and noisy inputs.
    function automatic cyc_t base(logic [31:0] inst);
        bit [2:0] n;
        n = 3'($urandom);
        return mk(0, n[0], n[1], n[2], inst, 0, 0, 0, 0, 0, 2'd0, 0,
                  2'd0, m_st, m_fc, m_ret);
    endfunction

    function automatic void filler(int n);
        for (int i = 0; i < n; i++) q.push_back(base($urandom));
    endfunction

    function automatic void do_reset();
        cyc_t c;
        c = base($urandom);
        c.rst = 1;
        q.push_back(c);
        m_st = 0; m_fc = 0; m_ret = 0; m_dead = 0;
    endfunction

    // Expands one instruction into its expected per-cycle trace.
    // ilat/dlat: number of no-ack cycles before the ack.
    function automatic void gen(logic [31:0] inst, int ilat, int dlat,
                                bit bt);
        cyc_t c;
        logic [6:0] op;
        op = inst[6:0];
        if (m_dead) begin
            filler(3);
            return;
        end
        m_st = 0;
        for (int k = 0; k < 8; k++) begin
            c = base($urandom);
            c.ireq = 1;
            if (k < ilat) begin
                c.ia = 0;
                q.push_back(c);
                if (k == 7) begin
                    m_st = 6; m_fc = 2; m_dead = 1;
                    return;
                end
            end else begin
                c.ia = 1;
                c.irw = 1;
                q.push_back(c);
                break;
            end
        end
        m_st = 1;
        q.push_back(base(inst));
        if (!legal(op)) begin
            m_st = 6; m_fc = 1; m_dead = 1;
            return;
        end
        if (op == OP_SYS) begin
            m_ret++; m_st = 5; m_dead = 1;
            return;
        end
        m_st = 2;
        c = base(inst);
        c.bt = bt;
        if (op == OP_B) begin
            c.pcw = 1;
            c.psrc = {1'b0, bt};
            q.push_back(c);
            m_ret++; m_st = 0;
            return;
        end
        q.push_back(c);
        if (op == OP_L || op == OP_S) begin
            m_st = 3;
            for (int k = 0; k < 8; k++) begin
                c = base(inst);
                c.dreq = 1;
                c.dwe = (op == OP_S);
                if (k < dlat) begin
                    c.da = 0;
                    q.push_back(c);
                    if (k == 7) begin
                        m_st = 6; m_fc = 3; m_dead = 1;
                        return;
                    end
                end else begin
                    c.da = 1;
                    if (op == OP_S) begin
                        c.pcw = 1;
                        q.push_back(c);
                        m_ret++; m_st = 0;
                        return;
                    end
                    q.push_back(c);
                    break;
                end
            end
        end
        m_st = 4;
        c = base(inst);
        c.rw = (inst[11:7] != 5'd0);
        c.wsel = (op == OP_L) ? 2'd1 :
                 (op == OP_J || op == OP_JR) ? 2'd2 :
                 (op == OP_LUI) ? 2'd3 : 2'd0;
        c.pcw = 1;
        c.psrc = (op == OP_J) ? 2'd1 : (op == OP_JR) ? 2'd2 : 2'd0;
        q.push_back(c);
        m_ret++; m_st = 0;
    endfunction

    function automatic logic [46:0] pack(cyc_t c);
        return {c.ireq, c.irw, c.dreq, c.dwe, c.rw, c.wsel, c.pcw,
                c.psrc, c.st, c.fc, c.ret};
    endfunction

    task automatic apply(input cyc_t c, input string tag);
        logic [46:0] got, exp;
        @(negedge clk);
        rst = c.rst;
        bus.i_imem_ack = c.ia;
        bus.i_dmem_ack = c.da;
        bus.i_branch_taken = c.bt;
        bus.i_inst = c.inst;
        #1;
        got = {bus.o_imem_req, bus.o_ir_write, bus.o_dmem_req,
               bus.o_dmem_we, bus.o_reg_write, bus.o_wb_sel,
               bus.o_pc_write, bus.o_pc_src, bus.o_state,
               bus.o_fault_cause, bus.o_retired};
        exp = pack(c);
        checks++;
        cyc_no++;
        if (got === exp) passed++;
        else
            $display("FAIL %s cyc%0d: got %h required %h (req,irw,dreq,we,rw,wsel,pcw,psrc,st,fc,ret)",
                     tag, cyc_no, got, exp);
    endtask

    task automatic run_q(input string tag);
        foreach (q[i]) apply(q[i], tag);
        q.delete();
    endtask

    cyc_t tbl[10];
    logic [31:0] saved;
    logic [31:0] r;
    logic [6:0]  ops[11];
    int          dreq_n;

    initial begin
        bus.i_inst = '0;
        bus.i_imem_ack = 1'b1;
        bus.i_dmem_ack = 1'b0;
        bus.i_branch_taken = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // ADDI x5 then ECALL, ack in the first fetch cycle.
        tbl[0] = mk(1,1,1,1,32'h0,         0,0,0,0,0,0,0,0,3'd0,0,32'd0);
        tbl[1] = mk(0,1,0,0,32'h0,         1,1,0,0,0,0,0,0,3'd0,0,32'd0);
        tbl[2] = mk(0,0,1,0,32'h00500293,  0,0,0,0,0,0,0,0,3'd1,0,32'd0);
        tbl[3] = mk(0,1,1,1,32'h00500293,  0,0,0,0,0,0,0,0,3'd2,0,32'd0);
        tbl[4] = mk(0,1,1,0,32'h00500293,  0,0,0,0,1,0,1,0,3'd4,0,32'd0);
        tbl[5] = mk(0,0,1,0,32'h0,         1,0,0,0,0,0,0,0,3'd0,0,32'd1);
        tbl[6] = mk(0,1,0,0,32'h0,         1,1,0,0,0,0,0,0,3'd0,0,32'd1);
        tbl[7] = mk(0,1,1,0,32'h00000073,  0,0,0,0,0,0,0,0,3'd1,0,32'd1);
        tbl[8] = mk(0,1,1,1,32'h00000073,  0,0,0,0,0,0,0,0,3'd5,0,32'd2);
        tbl[9] = mk(0,1,0,1,32'hFFFFFFFF,  0,0,0,0,0,0,0,0,3'd5,0,32'd2);
        for (int i = 0; i < 10; i++) apply(tbl[i], "table");
        m_st = 5; m_ret = 2; m_dead = 1;
        do_reset();
        run_q("reset_halt");

        // LW x1, ack on the third MEM cycle.
        gen(32'h00002083, 0, 2, 0);
        dreq_n = 0;
        foreach (q[i]) if (q[i].dreq) dreq_n++;
        checks++;
        if (dreq_n == 3 && q.size() == 7) passed++;
        else $display("FAIL lw_shape: got dreq %0d len %0d required 3 7",
                      dreq_n, q.size());
        run_q("lw");
        gen(32'h00000063, 1, 0, 1);
        gen(32'h00000063, 0, 0, 0);
        run_q("beq");
        gen(32'h0000007F, 0, 0, 0);
        filler(10);
        do_reset();
        run_q("illegal");
        gen(32'h00500293, 9, 0, 0);
        filler(4);
        do_reset();
        run_q("imem_to");
        gen(32'h00500293, 7, 0, 0);
        gen(32'h00102023, 0, 7, 0);
        run_q("ack_8th");
        gen(32'h00102023, 0, 9, 0);
        filler(3);
        do_reset();
        run_q("dmem_to");
        gen(32'h00000013, 0, 0, 0);
        gen(32'h008000EF, 0, 0, 0);
        gen(32'h000080E7, 0, 0, 0);
        gen(32'h123450B7, 0, 0, 0);
        gen(32'h00001097, 0, 0, 0);
        gen(32'h00100073, 2, 0, 0);
        filler(3);
        do_reset();
        run_q("misc");

        // Reset landing on the WB cycle of a JAL must suppress its strobes.
        saved = m_ret;
        gen(32'h008000EF, 0, 0, 0);
        q[$].rst = 1;
        q[$].rw = 0; q[$].wsel = 0; q[$].pcw = 0; q[$].psrc = 0;
        q[$].ret = saved;
        m_st = 0; m_fc = 0; m_ret = 0; m_dead = 0;
        gen(32'h00000013, 0, 0, 0);
        run_q("mid_rst");

        ops = '{OP_R, OP_I, OP_L, OP_S, OP_B, OP_J, OP_JR, OP_LUI,
                OP_AUI, OP_SYS, 7'h7F};
        for (int n = 0; n < 300; n++) begin
            int sel, il, dl;
            r = $urandom;
            sel = ($urandom_range(0, 39) == 0) ? $urandom_range(9, 10)
                                              : $urandom_range(0, 8);
            il = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3)
                                           : $urandom_range(6, 9);
            dl = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3)
                                           : $urandom_range(6, 9);
            gen({r[31:7], ops[sel]}, il, dl, r[20]);
            if (m_dead) begin
                filler(2);
                do_reset();
            end
            run_q("random");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
